// File: rtl/mandel_job_scheduler_pkg.sv
// Shared constants and state type for the Mandelbrot job scheduler.
// Frame geometry defaults, bus widths and the scheduler FSM states.
package mandel_pkg;

    localparam int H_DISPLAY    = 640;
    localparam int V_DISPLAY    = 480;
    localparam int FRAME_PIXELS = H_DISPLAY * V_DISPLAY;

    localparam int ADDR_W  = 19;
    localparam int COLOR_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_e;

endpackage

// File: rtl/mandel_job_scheduler_if.sv
// Job dispatch, result return and frame-memory write bus.
// master: scheduler side; slave: calc units plus frame memory.
interface mandel_job_scheduler_if #(
    parameter int NUM_UNITS = 4,
    parameter int ADDR_W    = mandel_pkg::ADDR_W,
    parameter int COLOR_W   = mandel_pkg::COLOR_W
);

    logic [NUM_UNITS-1:0]         job_valid;
    logic [NUM_UNITS-1:0]         job_ready;
    logic [9:0]                   job_x;
    logic [9:0]                   job_y;
    logic [ADDR_W-1:0]            job_addr;
    logic [NUM_UNITS-1:0]         res_valid;
    logic [NUM_UNITS-1:0]         res_ready;
    logic [NUM_UNITS*ADDR_W-1:0]  res_addr;
    logic [NUM_UNITS*COLOR_W-1:0] res_color;
    logic                         mem_we;
    logic [ADDR_W-1:0]            mem_addr;
    logic [COLOR_W-1:0]           mem_wdata;

    modport master (
        output job_valid, job_x, job_y, job_addr,
        output res_ready, mem_we, mem_addr, mem_wdata,
        input  job_ready, res_valid, res_addr, res_color
    );

    modport slave (
        input  job_valid, job_x, job_y, job_addr,
        input  res_ready, mem_we, mem_addr, mem_wdata,
        output job_ready, res_valid, res_addr, res_color
    );

endinterface

// File: rtl/mandel_job_scheduler_rr_arbiter.sv
// Round-robin arbiter: one-hot grant over req_i searching from ptr.
// Ports: req_i requests, advance_i moves ptr past winner, grant_o.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] req_i,
    input  logic         advance_i,
    output logic [N-1:0] grant_o
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;
    logic [PW-1:0] sel;
    logic          found;

    always_comb begin
        grant_o = '0;
        found   = 1'b0;
        sel     = ptr_q;
        for (int i = 0; i < N; i++) begin
            if (!found && req_i[(int'(ptr_q) + i) % N]) begin
                found = 1'b1;
                sel   = PW'((int'(ptr_q) + i) % N);
            end
        end
        if (found) grant_o[sel] = 1'b1;

        ptr_d = ptr_q;
        if (advance_i && found) begin
            ptr_d = (sel == PW'(N - 1)) ? '0 : sel + PW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) ptr_q <= '0;
        else       ptr_q <= ptr_d;
    end

endmodule

// File: rtl/mandel_job_scheduler.sv
// Hands pixel jobs to ready calc units and arbitrates their results
// onto the frame-memory write port. Ports: clk, reset, start, busy,
// done, bus (job offer, result grant, memory write).
module mandel_job_scheduler #(
    parameter int H_DISPLAY = mandel_pkg::H_DISPLAY,
    parameter int V_DISPLAY = mandel_pkg::V_DISPLAY,
    parameter int NUM_UNITS = 4,
    parameter int ADDR_W    = mandel_pkg::ADDR_W,
    parameter int COLOR_W   = mandel_pkg::COLOR_W
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic busy,
    output logic done,
    mandel_job_scheduler_if.master bus
);

    import mandel_pkg::*;

    localparam int                NPIX   = H_DISPLAY * V_DISPLAY;
    localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(NPIX - 1);
    localparam logic [ADDR_W-1:0] A_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   NPIX_C = (ADDR_W + 1)'(NPIX);
    localparam logic [ADDR_W:0]   C_ONE  = (ADDR_W + 1)'(1);
    localparam logic [9:0]        X_LAST = 10'(H_DISPLAY - 1);

    state_e               state_q, state_d;
    logic [9:0]           x_q, x_d;
    logic [9:0]           y_q, y_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [ADDR_W:0]      wcnt_q, wcnt_d;
    logic                 we_q, we_d;
    logic [ADDR_W-1:0]    maddr_q, maddr_d;
    logic [COLOR_W-1:0]   mdata_q, mdata_d;

    logic [NUM_UNITS-1:0] job_req, job_gnt;
    logic [NUM_UNITS-1:0] res_req, res_gnt;
    logic                 dispatch_en, wb_en;
    logic                 job_xfer, res_xfer;
    logic [ADDR_W-1:0]    wb_addr;
    logic [COLOR_W-1:0]   wb_color;

    assign dispatch_en = (state_q == RUN);
    assign wb_en       = (state_q == RUN) || (state_q == DRAIN);

    // Gating the requests keeps both grants zero outside their states,
    // so results stay held in the units rather than being dropped.
    assign job_req  = bus.job_ready & {NUM_UNITS{dispatch_en}};
    assign res_req  = bus.res_valid & {NUM_UNITS{wb_en}};
    assign job_xfer = |job_gnt;
    assign res_xfer = |res_gnt;

    rr_arbiter #(.N(NUM_UNITS)) u_job_arb (
        .clk       (clk),
        .reset     (reset),
        .req_i     (job_req),
        .advance_i (job_xfer),
        .grant_o   (job_gnt)
    );

    rr_arbiter #(.N(NUM_UNITS)) u_res_arb (
        .clk       (clk),
        .reset     (reset),
        .req_i     (res_req),
        .advance_i (res_xfer),
        .grant_o   (res_gnt)
    );

    always_comb begin
        wb_addr  = '0;
        wb_color = '0;
        for (int k = 0; k < NUM_UNITS; k++) begin
            if (res_gnt[k]) begin
                wb_addr  = bus.res_addr[k*ADDR_W +: ADDR_W];
                wb_color = bus.res_color[k*COLOR_W +: COLOR_W];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        addr_d  = addr_q;
        wcnt_d  = wcnt_q;
        we_d    = res_xfer;
        maddr_d = maddr_q;
        mdata_d = mdata_q;

        if (res_xfer) begin
            maddr_d = wb_addr;
            mdata_d = wb_color;
        end
        if (we_q) wcnt_d = wcnt_q + C_ONE;

        if (job_xfer) begin
            addr_d = addr_q + A_ONE;
            if (x_q == X_LAST) begin
                x_d = '0;
                y_d = y_q + 10'd1;
            end else begin
                x_d = x_q + 10'd1;
            end
        end

        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    x_d     = '0;
                    y_d     = '0;
                    addr_d  = '0;
                    wcnt_d  = '0;
                end
            end
            RUN: begin
                if (job_xfer && addr_q == LAST_A) state_d = DRAIN;
            end
            DRAIN: begin
                // Leave on the final write so done shows the next cycle.
                if (we_q && (wcnt_q + C_ONE) == NPIX_C) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            addr_q  <= '0;
            wcnt_q  <= '0;
            we_q    <= 1'b0;
            maddr_q <= '0;
            mdata_q <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            addr_q  <= addr_d;
            wcnt_q  <= wcnt_d;
            we_q    <= we_d;
            maddr_q <= maddr_d;
            mdata_q <= mdata_d;
        end
    end

    assign busy          = wb_en;
    assign done          = (state_q == DONE);
    assign bus.job_valid = job_gnt;
    assign bus.job_x     = x_q;
    assign bus.job_y     = y_q;
    assign bus.job_addr  = addr_q;
    assign bus.res_ready = res_gnt;
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = maddr_q;
    assign bus.mem_wdata = mdata_q;

endmodule

// File: tb/tb_mandel_job_scheduler.sv
// Testbench for mandel_job_scheduler on a 4x2 frame with 4 units.
// Behavioural unit/frame model drives and checks every cycle.
module tb_mandel_job_scheduler;

    localparam int H    = 4;
    localparam int V    = 2;
    localparam int NU   = 4;
    localparam int AW   = 19;
    localparam int CW   = 8;
    localparam int NPIX = H * V;

    typedef struct {
        int addr;
        int col;
        int due;
    } res_t;

    logic clk;
    logic reset;
    logic start;
    logic busy;
    logic done;

    mandel_job_scheduler_if #(
        .NUM_UNITS(NU), .ADDR_W(AW), .COLOR_W(CW)
    ) bus ();

    mandel_job_scheduler #(
        .H_DISPLAY(H), .V_DISPLAY(V), .NUM_UNITS(NU),
        .ADDR_W(AW), .COLOR_W(CW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .busy  (busy),
        .done  (done),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: 0 idle, 1 frame in progress, 2 frame complete
    res_t uq[NU][$];
    int   m_phase, m_issued, m_written, m_dptr, m_wptr, cyc;
    bit   m_pend;
    int   m_paddr, m_pcol;
    int   checks, errors;
    int   obs_we;
    int   obs_units[$];
    int   obs_runits[$];
    int   obs_waddr[$];

    task automatic model_clear();
        m_phase = 0; m_issued = 0; m_written = 0;
        m_dptr = 0; m_wptr = 0; m_pend = 0;
        for (int u = 0; u < NU; u++) uq[u].delete();
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        start = 1'b0;
        bus.job_ready = '0;
        bus.res_valid = '0;
        bus.res_addr  = '0;
        bus.res_color = '0;
        model_clear();
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic step(input logic [NU-1:0] mask, input bit rnd,
                        input int lmin, input int lmax, input bit st);
        logic [NU-1:0] rdy, rv, ejv, err;
        int  k, naddr, ncol;
        bit  npend;
        @(negedge clk);
        rdy = mask;
        if (rnd) rdy = rdy & NU'($urandom);
        rv = '0;
        bus.res_addr  = '0;
        bus.res_color = '0;
        for (int u = 0; u < NU; u++) begin
            if (uq[u].size() > 0 && uq[u][0].due <= cyc) begin
                rv[u] = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
                bus.res_addr[u*AW +: AW]  = AW'(uq[u][0].addr);
                bus.res_color[u*CW +: CW] = CW'(uq[u][0].col);
            end
        end
        bus.job_ready = rdy;
        bus.res_valid = rv;
        start = st;
        #1;

        checks += 2;
        if (busy !== (m_phase == 1)) begin
            errors++;
            $display("FAIL busy cyc %0d: got %b exp %b", cyc, busy, m_phase == 1);
        end
        if (done !== (m_phase == 2)) begin
            errors++;
            $display("FAIL done cyc %0d: got %b exp %b", cyc, done, m_phase == 2);
        end

        ejv = '0;
        k = -1;
        if (m_phase == 1 && m_issued < NPIX)
            for (int i = 0; i < NU; i++)
                if (k < 0 && rdy[(m_dptr + i) % NU]) k = (m_dptr + i) % NU;
        if (k >= 0) ejv[k] = 1'b1;
        checks += 4;
        if (bus.job_valid !== ejv) begin
            errors++;
            $display("FAIL job_valid cyc %0d: got %b exp %b", cyc, bus.job_valid, ejv);
        end
        if (bus.job_addr !== AW'(m_issued)) begin
            errors++;
            $display("FAIL job_addr cyc %0d: got %0d exp %0d", cyc, bus.job_addr, m_issued);
        end
        if (bus.job_x !== 10'(m_issued % H)) begin
            errors++;
            $display("FAIL job_x cyc %0d: got %0d exp %0d", cyc, bus.job_x, m_issued % H);
        end
        if (bus.job_y !== 10'(m_issued / H)) begin
            errors++;
            $display("FAIL job_y cyc %0d: got %0d exp %0d", cyc, bus.job_y, m_issued / H);
        end
        for (int u = 0; u < NU; u++) if (bus.job_valid[u] === 1'b1) obs_units.push_back(u);
        if (k >= 0) begin
            uq[k].push_back('{addr: m_issued,
                              col: int'($urandom_range(0, 255)),
                              due: cyc + int'($urandom_range(lmin, lmax))});
            m_dptr = (k + 1) % NU;
            m_issued++;
        end

        err = '0;
        k = -1;
        if (m_phase == 1)
            for (int i = 0; i < NU; i++)
                if (k < 0 && rv[(m_wptr + i) % NU]) k = (m_wptr + i) % NU;
        if (k >= 0) err[k] = 1'b1;
        checks++;
        if (bus.res_ready !== err) begin
            errors++;
            $display("FAIL res_ready cyc %0d: got %b exp %b", cyc, bus.res_ready, err);
        end
        for (int u = 0; u < NU; u++) if (bus.res_ready[u] === 1'b1) obs_runits.push_back(u);
        npend = 0; naddr = 0; ncol = 0;
        if (k >= 0) begin
            npend = 1;
            naddr = uq[k][0].addr;
            ncol  = uq[k][0].col;
            uq[k].delete(0);
            m_wptr = (k + 1) % NU;
        end

        checks++;
        if (bus.mem_we !== m_pend) begin
            errors++;
            $display("FAIL mem_we cyc %0d: got %b exp %b", cyc, bus.mem_we, m_pend);
        end
        if (m_pend) begin
            checks += 2;
            if (bus.mem_addr !== AW'(m_paddr)) begin
                errors++;
                $display("FAIL mem_addr cyc %0d: got %0d exp %0d", cyc, bus.mem_addr, m_paddr);
            end
            if (bus.mem_wdata !== CW'(m_pcol)) begin
                errors++;
                $display("FAIL mem_wdata cyc %0d: got %0d exp %0d", cyc, bus.mem_wdata, m_pcol);
            end
            m_written++;
        end
        if (bus.mem_we === 1'b1) begin
            obs_we++;
            obs_waddr.push_back(int'(bus.mem_addr));
        end

        if (m_phase == 1 && m_pend && m_written == NPIX) begin
            m_phase = 2;
        end else if (st && m_phase != 1) begin
            m_phase = 1; m_issued = 0; m_written = 0;
        end
        m_pend  = npend;
        m_paddr = naddr;
        m_pcol  = ncol;
        cyc++;
    endtask

    task automatic run_frame(input logic [NU-1:0] mask, input bit rnd,
                             input int lmin, input int lmax);
        int n;
        n = 0;
        step(mask, rnd, lmin, lmax, 1'b1);
        while (m_phase != 2 && n < 2000) begin
            step(mask, rnd, lmin, lmax, rnd && ($urandom_range(0, 15) == 0));
            n++;
        end
        checks++;
        if (m_phase != 2) begin
            errors++;
            $display("FAIL frame_timeout: got written %0d exp %0d", m_written, NPIX);
        end
        repeat (2) step(mask, rnd, lmin, lmax, 1'b0);
    endtask

    task automatic test_reset();
        apply_reset();
        bus.job_ready = '1;
        bus.res_valid = '1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            checks += 4;
            if ({busy, done, bus.mem_we} !== 3'b000) begin
                errors++;
                $display("FAIL reset_flags: got %b exp 000", {busy, done, bus.mem_we});
            end
            if (bus.job_valid !== '0 || bus.res_ready !== '0) begin
                errors++;
                $display("FAIL reset_grants: got %b/%b exp 0/0", bus.job_valid, bus.res_ready);
            end
            if (bus.mem_addr !== '0 || bus.mem_wdata !== '0) begin
                errors++;
                $display("FAIL reset_mem: got %0d/%0d exp 0/0", bus.mem_addr, bus.mem_wdata);
            end
            if (bus.job_x !== '0 || bus.job_y !== '0 || bus.job_addr !== '0) begin
                errors++;
                $display("FAIL reset_job: got %0d,%0d,%0d exp 0,0,0",
                         bus.job_x, bus.job_y, bus.job_addr);
            end
        end
        bus.job_ready = '0;
        bus.res_valid = '0;
    endtask

    task automatic test_small_frame();
        apply_reset();
        obs_units.delete();
        obs_we = 0;
        run_frame(4'b0011, 1'b0, 3, 3);
        checks += 2;
        if (obs_we !== NPIX) begin
            errors++;
            $display("FAIL small_we_count: got %0d exp %0d", obs_we, NPIX);
        end
        if (obs_units.size() !== NPIX) begin
            errors++;
            $display("FAIL small_job_count: got %0d exp %0d", obs_units.size(), NPIX);
        end
        for (int i = 0; i < obs_units.size() && i < NPIX; i++) begin
            checks++;
            if (obs_units[i] !== i % 2) begin
                errors++;
                $display("FAIL small_alt job %0d: got unit %0d exp %0d", i, obs_units[i], i % 2);
            end
        end
    endtask

    task automatic test_only_unit2();
        int n;
        obs_units.delete();
        step(4'b0100, 1'b0, 2, 2, 1'b1);
        step(4'b0100, 1'b0, 2, 2, 1'b0);
        checks++;
        if (done !== 1'b0 || bus.job_addr !== '0 || bus.job_valid !== 4'b0100) begin
            errors++;
            $display("FAIL restart: got done %b addr %0d jv %b exp 0 0 0100",
                     done, bus.job_addr, bus.job_valid);
        end
        n = 0;
        while (m_phase != 2 && n < 500) begin
            step(4'b0100, 1'b0, 2, 2, 1'b0);
            n++;
        end
        checks++;
        if (m_phase != 2) begin
            errors++;
            $display("FAIL unit2_timeout: got written %0d exp %0d", m_written, NPIX);
        end
        step(4'b0100, 1'b0, 2, 2, 1'b0);
        checks++;
        if (obs_units.size() !== NPIX) begin
            errors++;
            $display("FAIL unit2_count: got %0d exp %0d", obs_units.size(), NPIX);
        end
        foreach (obs_units[i]) begin
            checks++;
            if (obs_units[i] !== 2) begin
                errors++;
                $display("FAIL unit2_only job %0d: got unit %0d exp 2", i, obs_units[i]);
            end
        end
    endtask

    task automatic test_random();
        for (int f = 0; f < 4; f++) run_frame(4'b1111, 1'b1, 1, 6);
    endtask

    task automatic test_contention();
        apply_reset();
        step(4'b0000, 1'b0, 1, 1, 1'b1);
        for (int u = 0; u < NU; u++)
            uq[u].push_back('{addr: 10 + u, col: 'h40 + u, due: 0});
        obs_runits.delete();
        obs_waddr.delete();
        repeat (6) step(4'b0000, 1'b0, 1, 1, 1'b0);
        checks += 2;
        if (obs_runits.size() !== 4) begin
            errors++;
            $display("FAIL cont_grants: got %0d exp 4", obs_runits.size());
        end
        if (obs_waddr.size() !== 4) begin
            errors++;
            $display("FAIL cont_writes: got %0d exp 4", obs_waddr.size());
        end
        for (int i = 0; i < 4 && i < obs_runits.size() && i < obs_waddr.size(); i++) begin
            checks += 2;
            if (obs_runits[i] !== i) begin
                errors++;
                $display("FAIL cont_order %0d: got %0d exp %0d", i, obs_runits[i], i);
            end
            if (obs_waddr[i] !== 10 + i) begin
                errors++;
                $display("FAIL cont_addr %0d: got %0d exp %0d", i, obs_waddr[i], 10 + i);
            end
        end
    endtask

    task automatic test_reset_drain();
        int n;
        apply_reset();
        step(4'b1111, 1'b0, 12, 12, 1'b1);
        n = 0;
        while (m_issued < NPIX && n < 50) begin
            step(4'b1111, 1'b0, 12, 12, 1'b0);
            n++;
        end
        repeat (2) step(4'b1111, 1'b0, 12, 12, 1'b0);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checks += 3;
        if (busy !== 1'b0 || done !== 1'b0 || bus.mem_we !== 1'b0) begin
            errors++;
            $display("FAIL abort_flags: got %b exp 000", {busy, done, bus.mem_we});
        end
        if (bus.job_x !== '0 || bus.job_y !== '0 || bus.job_addr !== '0) begin
            errors++;
            $display("FAIL abort_cnt: got %0d,%0d,%0d exp 0,0,0",
                     bus.job_x, bus.job_y, bus.job_addr);
        end
        if (bus.job_valid !== '0 || bus.res_ready !== '0) begin
            errors++;
            $display("FAIL abort_grants: got %b/%b exp 0/0", bus.job_valid, bus.res_ready);
        end
        apply_reset();
        step(4'b1111, 1'b0, 2, 2, 1'b1);
        step(4'b1111, 1'b0, 2, 2, 1'b0);
        checks++;
        if (bus.job_addr !== '0 || bus.job_x !== '0 || bus.job_y !== '0) begin
            errors++;
            $display("FAIL abort_restart: got %0d,%0d,%0d exp 0,0,0",
                     bus.job_x, bus.job_y, bus.job_addr);
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        bus.job_ready = '0;
        bus.res_valid = '0;
        bus.res_addr  = '0;
        bus.res_color = '0;
        checks = 0;
        errors = 0;
        cyc    = 0;
        obs_we = 0;
        model_clear();
        test_reset();
        test_small_frame();
        test_only_unit2();
        test_random();
        test_contention();
        test_reset_drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mandel_job_scheduler.md
Name: mandel_job_scheduler

Overview:
Work scheduler and write-back arbiter for the parallel Mandelbrot calculation units. Hands out pixel jobs (x, y, frame address) on demand to whichever unit is ready, instead of a fixed static split. Collects the units' colour results through a round-robin arbiter onto the single frame-memory write port. Raises done once every pixel of the frame has been written.

Parameters:
H_DISPLAY, 640, frame width in pixels
V_DISPLAY, 480, frame height in pixels
NUM_UNITS, 4, number of calculation units served (>=1)
ADDR_W, 19, frame-memory address width (must cover H_DISPLAY*V_DISPLAY-1)
COLOR_W, 8, colour/iteration result width

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
start  in  1  single-cycle pulse; begins a frame when idle or done
busy  out  1  high in RUN and DRAIN
done  out  1  high in DONE until the next start
job_valid  out  NUM_UNITS  one-hot job offer; a bit is high only for a unit whose job_ready is high
job_ready  in  NUM_UNITS  unit k can accept a job this cycle
job_x  out  10  pixel x of the offered job (shared by all units)
job_y  out  10  pixel y of the offered job
job_addr  out  ADDR_W  frame address tag of the offered job (y*H_DISPLAY+x)
res_valid  in  NUM_UNITS  unit k holds a finished result
res_ready  out  NUM_UNITS  one-hot result grant
res_addr  in  NUM_UNITS*ADDR_W  packed per-unit returned tags, unit k at [k*ADDR_W +: ADDR_W]
res_color  in  NUM_UNITS*COLOR_W  packed per-unit results
mem_we  out  1  frame-memory write strobe
mem_addr  out  ADDR_W  write address
mem_wdata  out  COLOR_W  write data

Behaviour:
- Reset: state IDLE; busy=0, done=0, mem_we=0, mem_addr=0, mem_wdata=0; x/y/addr counters=0; issued and written counts=0; both round-robin pointers=0.
- States:
  - IDLE: start -> RUN; counters cleared.
  - RUN: dispatch and write-back active. When the last job is transferred -> DRAIN.
  - DRAIN: write-back only. When written count reaches H_DISPLAY*V_DISPLAY -> DONE.
  - DONE: done=1. start -> RUN with counters cleared, same cycle done drops to 0.
- start is ignored in RUN and DRAIN.
- Dispatch (RUN only, combinational offer):
  - job_valid is the one-hot round-robin grant over job_ready, searching from the dispatch pointer.
  - A transfer occurs in the cycle a bit of job_valid is high.
  - On transfer: dispatch pointer = (k+1) mod NUM_UNITS; x increments; at x=H_DISPLAY-1, x wraps to 0 and y increments; addr increments.
  - job_x, job_y and job_addr always show the current counters.
  - At most one job is transferred per cycle.
  - After the last job (x=H_DISPLAY-1, y=V_DISPLAY-1, addr=H_DISPLAY*V_DISPLAY-1), job_valid is 0.
- Write-back (RUN and DRAIN):
  - res_ready is the one-hot round-robin grant over res_valid, searching from its own pointer.
  - Handshake is complete when res_valid[k] & res_ready[k].
  - Next cycle: mem_we=1, mem_addr=res_addr slice k, mem_wdata=res_color slice k. Latency is one clock; at most one write per cycle.
  - Write-back pointer then = (k+1) mod NUM_UNITS.
  - In IDLE and DONE, res_ready=0 and results are held off (not dropped).
- Dispatch and write-back run independently in the same cycle; one unit may receive a job and return a result simultaneously.
- Written count increments on every mem_we. The DRAIN->DONE transition fires in the cycle after the final mem_we. done rises one cycle after that last write.
- Reset asserted mid-frame aborts immediately to the reset state; any partially written frame is abandoned.
- Arithmetic: counters unsigned, no overflow possible within a frame.

Decomposition:
- Shared package mandel_pkg holds:
  - the H_DISPLAY, V_DISPLAY, and FRAME_PIXELS constants;
  - the ADDR_W and COLOR_W widths;
  - the state enum (IDLE, RUN, DRAIN, DONE).
- One sub-module: rr_arbiter (parameter N; inputs req[N], advance; output grant[N] one-hot; internal pointer). Instantiated twice, once for dispatch and once for write-back.

Test Plan:
- Reset-only test, no start: after reset, all outputs are 0; job_valid=0 and res_ready=0 for 20 cycles.
- Small frame, H=4, V=2, N=2, both units always ready, results returned 3 cycles after each job: jobs go out alternately unit0/unit1 with addr 0..7. There are exactly 8 mem_we pulses with mem_wdata equal to the returned colour. done rises one cycle after the 8th write; busy falls in the same cycle.
- Contention, N=4: all res_valid high simultaneously with tags 10, 11, 12, 13. Grants go out in order 0, 1, 2, 3 on consecutive cycles; mem_addr sequence is 10, 11, 12, 13, one per cycle.
- Only unit 2 ever ready, H=4, V=2: all 8 jobs go to unit 2 in raster order (0,0), (1,0), (2,0), (3,0), (0,1) … (3,1); job_valid is never high on other bits.
- Reset asserted in DRAIN with results pending: next cycle state is IDLE, mem_we=0 and counters are 0. A following start restarts at job (0,0), addr 0.
- start pulsed during RUN has no effect on counters. start pulsed in DONE clears done and reissues addr 0.
